kb_ascii: RTL

KB_ASCII -- requirements
Module: kb_ascii

---
 rtl/kb_ascii.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kb_ascii.sv
// kb_ascii: pops PS/2 scan-set-2 codes from an upstream buffer, translates
// them to ASCII and offers each character on a valid/ready output.
// Optional feature macro: KB_ASCII_CAPS_LOCK_EN (caps-lock toggle on code 58).
//
// Handshake semantics:
//   upstream  - i_key_code is meaningful whenever i_kb_buf_empty=0; the block
//               pops it by raising o_rd_key_code for exactly the cycle whose
//               rising edge consumes it (only in IDLE, never when empty).
//   consumer  - o_ascii_valid=1 offers o_ascii; o_ascii is held stable until
//               the rising edge at which i_ascii_ready=1 completes the transfer.
//               i_ascii_ready is ignored while o_ascii_valid=0.
module kb_ascii #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [7:0]       i_key_code,
  input  logic             i_kb_buf_empty,
  output logic             o_rd_key_code,
  output logic [7:0]       o_ascii,
  output logic             o_ascii_valid,
  input  logic             i_ascii_ready,
  output logic [CNT_W-1:0] o_unmapped_cnt,
  output logic             o_caps,
  output logic [1:0]       o_dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       ascii_q, ascii_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_key_code;
  logic             caps_cur;
  logic             caps_key;
  logic             map_hit;
  logic [7:0]       map_char;
  logic             map_letter;

`ifdef KB_ASCII_CAPS_LOCK_EN
  logic caps_q, caps_d;
  assign caps_cur = caps_q;
  assign caps_key = (code_q == 8'h58);
`else
  assign caps_cur = 1'b0;
  assign caps_key = 1'b0;
`endif

  // Lowercase translation of the latched scan code; map_hit=0 for unmapped codes.
  always_comb begin
    map_hit  = 1'b1;
    map_char = 8'h00;
    case (code_q)
      8'h1C: map_char = 8'h61; 8'h32: map_char = 8'h62; 8'h21: map_char = 8'h63;
      8'h23: map_char = 8'h64; 8'h24: map_char = 8'h65; 8'h2B: map_char = 8'h66;
      8'h34: map_char = 8'h67; 8'h33: map_char = 8'h68; 8'h43: map_char = 8'h69;
      8'h3B: map_char = 8'h6A; 8'h42: map_char = 8'h6B; 8'h4B: map_char = 8'h6C;
      8'h3A: map_char = 8'h6D; 8'h31: map_char = 8'h6E; 8'h44: map_char = 8'h6F;
      8'h4D: map_char = 8'h70; 8'h15: map_char = 8'h71; 8'h2D: map_char = 8'h72;
      8'h1B: map_char = 8'h73; 8'h2C: map_char = 8'h74; 8'h3C: map_char = 8'h75;
      8'h2A: map_char = 8'h76; 8'h1D: map_char = 8'h77; 8'h22: map_char = 8'h78;
      8'h35: map_char = 8'h79; 8'h1A: map_char = 8'h7A;
      8'h45: map_char = 8'h30; 8'h16: map_char = 8'h31; 8'h1E: map_char = 8'h32;
      8'h26: map_char = 8'h33; 8'h25: map_char = 8'h34; 8'h2E: map_char = 8'h35;
      8'h36: map_char = 8'h36; 8'h3D: map_char = 8'h37; 8'h3E: map_char = 8'h38;
      8'h46: map_char = 8'h39;
      8'h29: map_char = 8'h20; 8'h5A: map_char = 8'h0D; 8'h66: map_char = 8'h08;
      8'h0D: map_char = 8'h09; 8'h76: map_char = 8'h1B;
      default: map_hit = 1'b0;
    endcase
    map_letter = (map_char >= 8'h61) && (map_char <= 8'h7A);
  end

  // FSM next-state, pop strobe, output character and unmapped counter.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ascii_d     = ascii_q;
    cnt_d       = cnt_q;
    rd_key_code = 1'b0;
`ifdef KB_ASCII_CAPS_LOCK_EN
    caps_d      = caps_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!i_kb_buf_empty) begin
          rd_key_code = 1'b1;
          code_d      = i_key_code;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (caps_key) begin
`ifdef KB_ASCII_CAPS_LOCK_EN
          caps_d = ~caps_q;
`endif
          state_d = ST_IDLE;
        end else if (map_hit) begin
          // Letters are 0x20 above their uppercase form.
          ascii_d = (map_letter && caps_cur) ? (map_char - 8'h20) : map_char;
          state_d = ST_SEND;
        end else begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_ascii_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      code_q  <= 8'h00;
      ascii_q <= 8'h00;
      cnt_q   <= '0;
`ifdef KB_ASCII_CAPS_LOCK_EN
      caps_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ascii_q <= ascii_d;
      cnt_q   <= cnt_d;
`ifdef KB_ASCII_CAPS_LOCK_EN
      caps_q  <= caps_d;
`endif
    end
  end

  // The pop strobe is combinational from IDLE, so gate it with reset to keep
  // it low for the whole time reset is held.
  assign o_rd_key_code  = rd_key_code & i_reset_n;
  assign o_ascii        = ascii_q;
  assign o_ascii_valid  = (state_q == ST_SEND);
  assign o_unmapped_cnt = cnt_q;
  assign o_caps         = caps_cur;
  assign o_dbg_state    = state_q;

endmodule
